// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: CPU trace FIFO of {pc,instr,seq} samples with FWFT valid/ready drain, drop counting and halt-loop freeze
module sm_trace_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int HALT_CYCLES = 4,
  parameter int SEQ_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic                  pc_valid,
  input  logic [31:0]           pc,
  input  logic [31:0]           instr,
  input  logic                  clear,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [31:0]           rd_pc,
  output logic [31:0]           rd_instr,
  output logic [SEQ_WIDTH-1:0]  rd_seq,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            dropped,
  output logic                  halted
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [31:0]           mem_pc    [DEPTH];
  logic [31:0]           mem_instr [DEPTH];
  logic [SEQ_WIDTH-1:0]  mem_seq   [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d, halted_q, halted_d, prev_valid_q, prev_valid_d;
  logic [7:0]            dropped_q, dropped_d, same_cnt_q, same_cnt_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [31:0]           prev_pc_q, prev_pc_d;
  logic                  sample, full, pop, push, drop;
  always_comb begin
    rd_valid     = count_q != '0;
    rd_pc        = rd_valid ? mem_pc[rd_q] : '0;
    rd_instr     = rd_valid ? mem_instr[rd_q] : '0;
    rd_seq       = rd_valid ? mem_seq[rd_q] : '0;
    count        = count_q;
    overflow     = overflow_q;
    dropped      = dropped_q;
    halted       = halted_q;
    sample       = cap_en & pc_valid & ~halted_q;
    full         = count_q[DEPTH_LOG2];
    pop          = rd_valid & rd_ready;
    push         = sample & (~full | pop);
    drop         = sample & full & ~pop;
    wr_d         = push ? wr_q + DEPTH_LOG2'(1) : wr_q;
    rd_d         = pop ? rd_q + DEPTH_LOG2'(1) : rd_q;
    count_d      = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    overflow_d   = overflow_q | drop;
    dropped_d    = (drop && dropped_q != 8'hff) ? dropped_q + 8'd1 : dropped_q;
    seq_d        = sample ? seq_q + SEQ_WIDTH'(1) : seq_q;
    same_cnt_d   = !sample ? same_cnt_q :
                   (prev_valid_q && pc == prev_pc_q) ? (same_cnt_q == 8'hff ? same_cnt_q : same_cnt_q + 8'd1) : 8'd0;
    prev_pc_d    = sample ? pc : prev_pc_q;
    prev_valid_d = prev_valid_q | sample;
    halted_d     = halted_q | (sample && same_cnt_d == 8'(HALT_CYCLES - 1));
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_q]    <= pc;
      mem_instr[wr_q] <= instr;
      mem_seq[wr_q]   <= seq_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
      halted_q     <= 1'b0;
      seq_q        <= '0;
      same_cnt_q   <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
      halted_q     <= halted_d;
      seq_q        <= seq_d;
      same_cnt_q   <= same_cnt_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
    end
  end
endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb_sm_trace_buffer: directed stimulus with a queue scoreboard checked by an independent drain monitor
module tb_sm_trace_buffer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] seq;
  } ent_t;
  logic        clk = 1'b0, rst = 1'b0, cap_en = 1'b0, pc_valid = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic [31:0] pc = '0, instr = '0;
  logic        rd_valid, overflow, halted;
  logic [31:0] rd_pc, rd_instr;
  logic [15:0] rd_seq;
  logic [4:0]  count;
  logic [7:0]  dropped;
  ent_t        q[$];
  int          n_vec = 0, n_err = 0, sb_vec = 0, sb_err = 0;
  sm_trace_buffer #(.DEPTH_LOG2(4), .HALT_CYCLES(4), .SEQ_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc_valid(pc_valid), .pc(pc), .instr(instr),
    .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_seq(rd_seq), .count(count), .overflow(overflow), .dropped(dropped), .halted(halted)
  );
  always #5 clk = ~clk;
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && !clear && rd_valid && rd_ready) begin
        sb_vec++;
        if (q.size() == 0) begin
          sb_err++;
          $display("FAIL sb_unexpected: got pc=%0h seq=%0d required no entry", rd_pc, rd_seq);
        end else begin
          e = q.pop_front();
          if ({rd_pc, rd_instr, rd_seq} !== e) begin
            sb_err++;
            $display("FAIL sb_entry: got pc=%0h instr=%0h seq=%0d required pc=%0h instr=%0h seq=%0d",
                     rd_pc, rd_instr, rd_seq, e.pc, e.instr, e.seq);
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask
  task automatic exp_ent(input int p, input int i, input int s);
    q.push_back({32'(p), 32'(i), 16'(s)});
  endtask
  task automatic smp(input int p, input int i);
    pc = 32'(p);
    instr = 32'(i);
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask
  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_count"}, 32'(count), 0);
    chk({nm, "_rd_valid"}, 32'(rd_valid), 0);
    chk({nm, "_rd_pc"}, rd_pc, 0);
    chk({nm, "_rd_instr"}, rd_instr, 0);
    chk({nm, "_rd_seq"}, 32'(rd_seq), 0);
    chk({nm, "_overflow"}, 32'(overflow), 0);
    chk({nm, "_dropped"}, 32'(dropped), 0);
    chk({nm, "_halted"}, 32'(halted), 0);
  endtask
  initial begin
    do_rst();
    cap_en = 1'b1;
    chk_zero("reset");
    for (int k = 0; k < 3; k++) begin
      exp_ent(k, 'hA0 + k, k);
      smp(k, 'hA0 + k);
    end
    chk("t1_count", 32'(count), 3);
    chk("t1_rd_valid", 32'(rd_valid), 1);
    chk("t1_head_pc", rd_pc, 0);
    chk("t1_head_seq", 32'(rd_seq), 0);
    drain(3);
    chk("t1_count_empty", 32'(count), 0);
    chk("t1_rd_valid_empty", 32'(rd_valid), 0);
    chk("t1_rd_pc_empty", rd_pc, 0);
    chk("t1_rd_seq_empty", 32'(rd_seq), 0);
    do_rst();
    for (int k = 0; k < 18; k++) begin
      if (k < 16) exp_ent(100 + k, k, k);
      smp(100 + k, k);
    end
    chk("t2_count", 32'(count), 16);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_dropped", 32'(dropped), 2);
    drain(16);
    chk("t2_count_empty", 32'(count), 0);
    for (int k = 0; k < 16; k++) begin
      exp_ent(200 + k, k, 18 + k);
      smp(200 + k, k);
    end
    rd_ready = 1'b1;
    exp_ent(300, 300, 34);
    smp(300, 300);
    rd_ready = 1'b0;
    chk("t3_count_full_pushpop", 32'(count), 16);
    chk("t3_dropped_kept", 32'(dropped), 2);
    drain(16);
    chk("t3_count_empty", 32'(count), 0);
    do_rst();
    exp_ent(5, 5, 0);
    smp(5, 5);
    for (int k = 0; k < 4; k++) begin
      chk("t4_not_halted_yet", 32'(halted), 0);
      exp_ent(6, 6, 1 + k);
      smp(6, 6);
    end
    chk("t4_halted", 32'(halted), 1);
    smp(7, 7);
    chk("t4_count", 32'(count), 5);
    chk("t4_halted_sticky", 32'(halted), 1);
    drain(5);
    chk("t4_count_drained", 32'(count), 0);
    do_rst();
    begin
      int s = 0;
      for (int k = 0; k < 10; k++) begin
        cap_en = !(k >= 3 && k <= 5);
        if (cap_en) begin
          exp_ent(400 + k, k, s);
          s++;
        end
        smp(400 + k, k);
        pc = 999;
        tick();
      end
    end
    cap_en = 1'b1;
    chk("t5_count", 32'(count), 7);
    drain(7);
    do_rst();
    for (int k = 0; k < 276; k++) smp(1000 + k, k);
    chk("t7_dropped_sat", 32'(dropped), 255);
    chk("t7_overflow", 32'(overflow), 1);
    chk("t7_count", 32'(count), 16);
    for (int r = 0; r < 2; r++) begin
      do_rst();
      for (int k = 0; k < 3; k++) smp(10 + k, k);
      for (int k = 0; k < 4; k++) smp(13, 13);
      chk("t6_count_pre", 32'(count), 7);
      chk("t6_halted_pre", 32'(halted), 1);
      if (r == 0) do_rst();
      else begin
        clear = 1'b1;
        pc_valid = 1'b1;
        rd_ready = 1'b1;
        tick();
        clear = 1'b0;
        pc_valid = 1'b0;
        rd_ready = 1'b0;
        q.delete();
      end
      chk_zero(r == 0 ? "t6_rst" : "t6_clear");
      exp_ent(50, 'h55, 0);
      smp(50, 'h55);
      chk("t6_rd_valid_after", 32'(rd_valid), 1);
      chk("t6_rd_seq_after", 32'(rd_seq), 0);
      chk("t6_rd_pc_after", rd_pc, 50);
      drain(1);
    end
    tick();
    chk("sb_all_drained", 32'(q.size()), 0);
    n_vec += sb_vec;
    n_err += sb_err;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sm_trace_buffer.md
Name: sm_trace_buffer

Overview:
- Capture buffer for the CPU execution trace: records {pc, instr, sequence stamp} once per CPU clock enable into a FIFO.
- Sits downstream of sm_top/sm_cpu; its inputs are the pc debug read (regAddr=0) and the current instruction word.
- A host or bench drains it through a valid/ready port.
- Detects a halt loop (PC stuck) and freezes capture, so the tail of a program run is preserved.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries.
- HALT_CYCLES, 4: consecutive identical-PC samples that declare halt (legal range 2..255).
- SEQ_WIDTH, 16: width of the per-sample sequence stamp.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- cap_en  in  1  capture enable; samples are ignored while 0.
- pc_valid  in  1  CPU cycle strobe: pc/instr are valid and are sampled this cycle.
- pc  in  32  current PC (word address).
- instr  in  32  current instruction word.
- clear  in  1  synchronous soft clear of FIFO and status.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO non-empty; head presented.
- rd_pc  out  32  head PC.
- rd_instr  out  32  head instruction.
- rd_seq  out  SEQ_WIDTH  head sequence stamp.
- count  out  DEPTH_LOG2+1  number of stored entries.
- overflow  out  1  sticky: at least one sample was dropped.
- dropped  out  8  number of dropped samples, saturating at 255.
- halted  out  1  sticky: halt loop detected; capture frozen.

Behaviour:
- Reset (rst=1 at posedge):
  - count=0, rd_valid=0, overflow=0, dropped=0, halted=0.
  - Sequence counter=0, same-PC counter=0, prev-valid=0.
  - rd_pc/rd_instr/rd_seq=0.
  - rst has priority over everything.
- clear=1: same effect as rst on all state, same cycle. Any push or pop in that cycle is ignored.
- Sample event: cap_en & pc_valid & !halted. No other cycle alters the sequence counter or the halt logic.
- On each sample event:
  - Entry = {pc, instr, seq}, where seq is the current sequence counter.
  - The sequence counter then increments, wrapping modulo 2**SEQ_WIDTH. It increments on dropped samples too, so gaps are visible to the consumer.
- Push:
  - If not full, the entry is written at the tail.
  - If full and no pop this cycle, the entry is dropped: overflow<=1 and dropped increments, saturating at 255.
  - If full and a pop occurs the same cycle, the push is accepted and count is unchanged.
- Pop:
  - Occurs when rd_valid & rd_ready.
  - Read side is first-word-fall-through: rd_* shows the head whenever rd_valid=1, and rd_* is 0 when rd_valid=0.
  - A push into an empty FIFO makes rd_valid=1 on the next cycle (1-cycle latency).
  - A pop with no push decrements count; simultaneous push and pop keep count.
  - Pointers wrap modulo depth; full is count==2**DEPTH_LOG2.
- Halt detection:
  - Tracks prev_pc and prev_valid across sample events.
  - Per sample: if prev_valid and pc==prev_pc, same_cnt increments (saturating); otherwise same_cnt=0.
  - prev_pc<=pc and prev_valid<=1 on every sample.
  - When a sample makes the run of identical PCs equal HALT_CYCLES (same_cnt reaches HALT_CYCLES-1), that sample is still pushed and halted<=1 on the following cycle.
  - halted stays sticky until rst/clear.
  - While halted, no samples are taken, but the FIFO can still be drained.
- cap_en=0 pauses sampling only. Halt and sequence state are held, not reset.
- No combinational path from rd_ready to rd_valid or to any rd_* output.

Test Plan:
- Reset, then 3 samples pc=0,1,2 with instr=A0,A1,A2 and rd_ready=0 → count=3, rd_valid=1, rd_pc=0, rd_seq=0. Raise rd_ready for 3 cycles → heads pc 1 (seq 1) then 2 (seq 2); count=0; rd_valid=0 and rd_* =0.
- rd_ready=0, 18 distinct samples into a depth-16 FIFO → count=16, overflow=1, dropped=2. Drain all 16 → rd_seq 0..15 in order.
- Full FIFO with simultaneous sample and pop → count stays 16, dropped unchanged. The new entry reads last with the expected seq.
- HALT_CYCLES=4, samples pc=5,6,6,6,6,7 → halted=1 the cycle after the 4th pc=6. FIFO holds 5,6,6,6,6 (count=5); pc=7 is not captured. Sequence counter ends at 5.
- pc_valid toggling every other cycle and cap_en=0 for 3 sample slots → only enabled strobes are captured; seq has no gaps for masked samples.
- Mid-run: count=7, halted=1; assert rst for 1 cycle → all outputs 0 the next cycle. Next sample gets seq=0 and rd_valid=1 one cycle later. Repeat using clear instead of rst → identical result.
